// File: rtl/rr_arbiter_if.sv
// Request/grant handshake between a set of requesters and rr_arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter_if #(
  parameter int REQ_NUM = 8
);
  localparam int IDX_W = $clog2(REQ_NUM);

  logic [REQ_NUM-1:0] req_i;
  logic               done_i;
  logic [REQ_NUM-1:0] gnt_o;
  logic [IDX_W-1:0]   gnt_idx_o;
  logic               gnt_val_o;
  logic               timeout_o;

  modport master (
    output req_i, done_i,
    input  gnt_o, gnt_idx_o, gnt_val_o, timeout_o
  );

  modport slave (
    input  req_i, done_i,
    output gnt_o, gnt_idx_o, gnt_val_o, timeout_o
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter holding one grant until done/request drop; optional
// forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter #(
  parameter int REQ_NUM  = 8,
  parameter int MAX_HOLD = 64
) (
  input  logic        clk_i,
  input  logic        arst_i,
  rr_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(REQ_NUM);

  if (REQ_NUM < 2 || REQ_NUM > 32 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("rr_arbiter: REQ_NUM must be 2..32 and MAX_HOLD >= 1");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [REQ_NUM-1:0] gnt_q;
  logic [IDX_W-1:0]   gnt_idx_q;
  logic               gnt_val_q;

  logic [REQ_NUM-1:0] cand_c;
  logic [IDX_W-1:0]   nxt_ptr_c;
  logic [IDX_W-1:0]   sel_ptr_c;
  logic [IDX_W-1:0]   sel_idx_c;
  logic               sel_found_c;
  logic               normal_rel_c;
  logic               forced_c;
  logic               release_c;

  // First set bit of req scanning ptr, ptr+1, ... with wrap; result {found, idx}.
  function automatic logic [IDX_W:0] rr_pick(input logic [REQ_NUM-1:0] req,
                                             input logic [IDX_W-1:0]   ptr);
    logic             found;
    logic [IDX_W-1:0] idx;
    int               k;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      k = int'(ptr) + i;
      if (k >= REQ_NUM) k = k - REQ_NUM;
      if (!found && req[IDX_W'(k)]) begin
        found = 1'b1;
        idx   = IDX_W'(k);
      end
    end
    return {found, idx};
  endfunction

  assign normal_rel_c = gnt_val_q & (bus.done_i | ~bus.req_i[gnt_idx_q]);
  assign release_c    = normal_rel_c | forced_c;
  assign nxt_ptr_c    = (gnt_idx_q == IDX_W'(REQ_NUM - 1)) ? '0 : gnt_idx_q + 1'b1;
  // While granted, the search starts after the current holder, which is masked out.
  assign sel_ptr_c    = gnt_val_q ? nxt_ptr_c : ptr_q;
  assign cand_c       = bus.req_i & ~gnt_q;
  assign {sel_found_c, sel_idx_c} = rr_pick(cand_c, sel_ptr_c);

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_q;
  logic              timeout_q;

  // hold_q counts cycles already held beyond the first, so this edge ends cycle MAX_HOLD.
  assign forced_c      = gnt_val_q & ~normal_rel_c & (hold_q == HOLD_W'(MAX_HOLD - 1));
  assign bus.timeout_o = timeout_q;
`else
  assign forced_c      = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      gnt_val_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= forced_c;
`endif
      case (state_q)
        IDLE: begin
          if (sel_found_c) begin
            state_q   <= GRANT;
            gnt_q     <= REQ_NUM'(1) << sel_idx_c;
            gnt_idx_q <= sel_idx_c;
            gnt_val_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= '0;
`endif
          end
        end
        GRANT: begin
          if (release_c) begin
            ptr_q <= nxt_ptr_c;
            if (sel_found_c) begin
              gnt_q     <= REQ_NUM'(1) << sel_idx_c;
              gnt_idx_q <= sel_idx_c;
`ifdef ARB_TIMEOUT_EN
              hold_q    <= '0;
`endif
            end else begin
              state_q   <= IDLE;
              gnt_q     <= '0;
              gnt_idx_q <= '0;
              gnt_val_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
              hold_q    <= '0;
`endif
            end
          end else begin
`ifdef ARB_TIMEOUT_EN
            if (hold_q != HOLD_W'(MAX_HOLD)) hold_q <= hold_q + 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.gnt_idx_o = gnt_idx_q;
  assign bus.gnt_val_o = gnt_val_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_rr_arbiter;
  localparam int N  = 8;
  localparam int IW = $clog2(N);
  localparam int MH = 4;

  logic clk_i  = 1'b0;
  logic arst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  rr_arbiter_if #(.REQ_NUM(N)) bus ();

  rr_arbiter #(.REQ_NUM(N), .MAX_HOLD(MH)) dut (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: who holds the grant (-1 = none), where the search starts,
  // how many cycles the holder has been visible, and the timeout pulse.
  int m_ptr, m_cur, m_held;
  bit m_to;

  function automatic int pick(input logic [N-1:0] r, input int p);
    logic [IW-1:0] k;
    for (int i = 0; i < N; i++) begin
      k = IW'((p + i) % N);
      if (r[k]) return int'(k);
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_cur = -1; m_held = 0; m_to = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] r;
    bit rel, forced;
    r = bus.req_i;
    m_to = 0;
    if (m_cur < 0) begin
      m_cur  = pick(r, m_ptr);
      m_held = 1;
    end else begin
      rel    = bus.done_i || !r[IW'(m_cur)];
      forced = 0;
`ifdef ARB_TIMEOUT_EN
      forced = !rel && (m_held == MH);
`endif
      if (rel || forced) begin
        m_ptr = (m_cur + 1) % N;
        r[IW'(m_cur)] = 1'b0;
        m_cur  = pick(r, m_ptr);
        m_held = 1;
        m_to   = forced;
      end else begin
        m_held++;
      end
    end
  endtask

  function automatic logic [IW+N+1:0] exp_v();
    logic [N-1:0]  g;
    logic [IW-1:0] ix;
    g  = (m_cur >= 0) ? (N'(1) << m_cur) : '0;
    ix = (m_cur >= 0) ? IW'(m_cur) : '0;
    return {m_cur >= 0, ix, g, m_to};
  endfunction

  function automatic logic [IW+N+1:0] obs_v();
    return {bus.gnt_val_o, bus.gnt_idx_o, bus.gnt_o, bus.timeout_o};
  endfunction

  function automatic string fmt(input logic [IW+N+1:0] v);
    return $sformatf("val=%b idx=%0d gnt=%h to=%b", v[IW+N+1], v[IW+N:N+1], v[N:1], v[0]);
  endfunction

  // Advance one clock: model sees the same inputs the DUT samples; sample 1 after the edge.
  task automatic step();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    bus.req_i  = '0;
    bus.done_i = 1'b0;
    arst_i = 1'b1;
    #2;
    arst_i = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bus.req_i = '0; bus.done_i = 1'b0; arst_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++;
    if (obs_v() !== '0) begin
      n_err++; $display("FAIL reset_state: got %s want all zero", fmt(obs_v()));
    end
    arst_i = 1'b0;
    bus.req_i = 8'h04;
    step();
    n_cmp++;
    if (bus.gnt_o !== 8'h04 || bus.gnt_val_o !== 1'b1) begin
      n_err++; $display("FAIL reset_pre_grant: got %s want gnt=04 val=1", fmt(obs_v()));
    end
    #2 arst_i = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (bus.gnt_o !== 8'h00 || bus.gnt_val_o !== 1'b0 || bus.gnt_idx_o !== '0) begin
      n_err++; $display("FAIL reset_async_drop: got %s want all zero", fmt(obs_v()));
    end
    #1 arst_i = 1'b0;
    bus.req_i = 8'h01;
    step();
    n_cmp++;
    if (bus.gnt_o !== 8'h01 || bus.gnt_val_o !== 1'b1 || obs_v() !== exp_v()) begin
      n_err++; $display("FAIL reset_regrant: got %s want %s", fmt(obs_v()), fmt(exp_v()));
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] want;
    do_reset();
    bus.req_i = '1;
    step();
    for (int k = 1; k <= N + 1; k++) begin
      want = N'(1) << ((k - 1) % N);
      n_cmp++;
      if (bus.gnt_o !== want || bus.gnt_idx_o !== IW'((k - 1) % N) || bus.gnt_val_o !== 1'b1
          || obs_v() !== exp_v()) begin
        n_err++; $display("FAIL rotation_%0d: got %s want gnt=%h", k - 1, fmt(obs_v()), want);
      end
      bus.done_i = 1'b1;
      step();
    end
    bus.done_i = 1'b0; bus.req_i = '0;
    step();
  endtask

  task automatic test_wrap_skip();
    do_reset();
    bus.req_i = 8'h20;
    step();
    bus.req_i = 8'h05; bus.done_i = 1'b1;
    step();
    n_cmp++;
    if (bus.gnt_idx_o !== 3'd0 || bus.gnt_val_o !== 1'b1 || obs_v() !== exp_v()) begin
      n_err++; $display("FAIL wrap_first: got %s want idx=0", fmt(obs_v()));
    end
    step();
    n_cmp++;
    if (bus.gnt_idx_o !== 3'd2 || bus.gnt_o !== 8'h04 || obs_v() !== exp_v()) begin
      n_err++; $display("FAIL wrap_skip: got %s want idx=2", fmt(obs_v()));
    end
    bus.done_i = 1'b0; bus.req_i = '0;
    step();
    n_cmp++;
    if (bus.gnt_val_o !== 1'b0 || bus.gnt_o !== 8'h00 || obs_v() !== exp_v()) begin
      n_err++; $display("FAIL wrap_idle: got %s want idle", fmt(obs_v()));
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    bus.req_i = 8'h08;
    step();
    bus.req_i = 8'h20;
    step();
    n_cmp++;
    if (bus.gnt_idx_o !== 3'd5 || bus.gnt_o !== 8'h20 || obs_v() !== exp_v()) begin
      n_err++; $display("FAIL req_drop: got %s want idx=5", fmt(obs_v()));
    end
    bus.req_i = 8'h3F;
    step();
    n_cmp++;
    if (bus.gnt_idx_o !== 3'd5 || obs_v() !== exp_v()) begin
      n_err++; $display("FAIL req_drop_stable: got %s want idx=5", fmt(obs_v()));
    end
    bus.req_i = '0;
    step();
  endtask

  task automatic test_sole_requester();
    do_reset();
    bus.req_i = 8'h00; bus.done_i = 1'b1;
    step();
    n_cmp++;
    if (bus.gnt_val_o !== 1'b0 || obs_v() !== exp_v()) begin
      n_err++; $display("FAIL idle_done_ignored: got %s want idle", fmt(obs_v()));
    end
    bus.done_i = 1'b0; bus.req_i = 8'h10;
    step();
    bus.done_i = 1'b1;
    step();
    n_cmp++;
    if (bus.gnt_val_o !== 1'b0 || bus.gnt_o !== 8'h00 || obs_v() !== exp_v()) begin
      n_err++; $display("FAIL sole_bubble: got %s want idle", fmt(obs_v()));
    end
    bus.done_i = 1'b0;
    step();
    n_cmp++;
    if (bus.gnt_idx_o !== 3'd4 || bus.gnt_val_o !== 1'b1 || obs_v() !== exp_v()) begin
      n_err++; $display("FAIL sole_regrant: got %s want idx=4", fmt(obs_v()));
    end
    bus.req_i = '0;
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    bus.req_i = 8'h03;
    step();
    for (int c = 1; c < MH; c++) begin
      step();
      n_cmp++;
      if (bus.gnt_idx_o !== 3'd0 || bus.timeout_o !== 1'b0 || obs_v() !== exp_v()) begin
        n_err++; $display("FAIL timeout_hold_%0d: got %s want idx=0 to=0", c, fmt(obs_v()));
      end
    end
`ifdef ARB_TIMEOUT_EN
    step();
    n_cmp++;
    if (bus.gnt_idx_o !== 3'd1 || bus.timeout_o !== 1'b1 || obs_v() !== exp_v()) begin
      n_err++; $display("FAIL timeout_fire: got %s want idx=1 to=1", fmt(obs_v()));
    end
    step();
    n_cmp++;
    if (bus.gnt_idx_o !== 3'd1 || bus.timeout_o !== 1'b0 || obs_v() !== exp_v()) begin
      n_err++; $display("FAIL timeout_pulse_width: got %s want idx=1 to=0", fmt(obs_v()));
    end
`else
    repeat (20) step();
    n_cmp++;
    if (bus.gnt_idx_o !== 3'd0 || bus.timeout_o !== 1'b0 || obs_v() !== exp_v()) begin
      n_err++; $display("FAIL no_timeout_hold: got %s want idx=0 to=0", fmt(obs_v()));
    end
`endif
    bus.req_i = '0;
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.req_i = N'($urandom);
        if ($urandom_range(0, 1) == 0) bus.req_i = bus.req_i & N'($urandom);
      end
      bus.done_i = ($urandom_range(0, 3) == 0);
      if (c == 300) begin
        do_reset();
        n_cmp++;
        if (obs_v() !== '0) begin
          n_err++; $display("FAIL random_async_reset: got %s want all zero", fmt(obs_v()));
        end
        bus.req_i = N'($urandom);
      end
      step();
      n_cmp++;
      if (obs_v() !== exp_v()) begin
        n_err++; $display("FAIL random_cyc%0d: req=%h got %s want %s", c, bus.req_i,
                          fmt(obs_v()), fmt(exp_v()));
      end
    end
    bus.req_i = '0; bus.done_i = 1'b0;
    step();
  endtask

  initial begin
    bus.req_i  = '0;
    bus.done_i = 1'b0;
    model_reset();
    test_reset();
    test_rotation();
    test_wrap_skip();
    test_req_drop();
    test_sole_requester();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
